i2s_rx: RTL and testbench
=========================

# i2s_rx

Synchronous I2S receiver: it oversamples an external bit clock, word select and serial data on the system clock and deserializes Philips-format stereo frames into parallel left/right samples. It is the receive-side counterpart of the `i2s` transmitter used for audio output. It feeds external digital audio (codec ADC, tape/line-in bridge) into core logic running on `clk_sys`. The block is clocked entirely by the system clock; the incoming `sclk` is treated as data, never as a clock.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of each output sample; slot bits beyond this are dropped.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on `sclk`, `lrclk` and `sdata`; minimum 2.

Ports:
- `clk` in 1: system clock (`clk_sys`). Must run at ≥4× the `sclk` frequency, with `sclk` high ≥2 and low ≥2 `clk` periods.
- `reset_n` in 1: reset, synchronous, active-low.
- `sclk` in 1: I2S bit clock, asynchronous.
- `lrclk` in 1: word select, asynchronous; 0 = left, 1 = right.
- `sdata` in 1: serial data, MSB first, asynchronous.
- `left_chan` out DATA_WIDTH: last complete left sample, two's complement.
- `right_chan` out DATA_WIDTH: last complete right sample.
- `sample_valid` out 1: one-cycle pulse when `left_chan`/`right_chan` update.
- `slot_err` out 1: one-cycle pulse when a completed slot had fewer than DATA_WIDTH bits.

## Operation
- All three inputs pass through SYNC_STAGES synchronizers. The synchronized `sclk` is delayed one more cycle for edge detection.
- Rising `sclk` edge (sync=1, delayed=0): sample synced `sdata` and `lrclk` together. Falling edges are ignored.
- Registers:
  - `prev_lr`: `lrclk` captured at the last rising edge.
  - `shreg`: DATA_WIDTH-bit shift register.
  - `cnt`: 0..DATA_WIDTH, saturating.
  - `left_hold`.
  - `armed`.
- Every rising edge: if `cnt` < DATA_WIDTH, shift `sdata` into the LSB of `shreg` and increment `cnt`. Otherwise discard the bit.
- Boundary detection: a rising edge where sampled `lrclk` ≠ `prev_lr`. This edge still carries the LSB of the previous slot because of the one-bit I2S delay. Process it as a data edge first, then close the slot:
  - Word = post-shift `shreg` left-justified by (DATA_WIDTH − post-shift `cnt`), with zeros filled into the LSBs.
  - If post-shift `cnt` < DATA_WIDTH and `armed`=1, pulse `slot_err`.
  - If `prev_lr`=0 (left slot closed) and `armed`: `left_hold` ← word.
  - If `prev_lr`=1 (right slot closed) and `armed`: `left_chan` ← `left_hold`, `right_chan` ← word, pulse `sample_valid`.
  - Clear `cnt` and `shreg`. Set `armed` ← 1. `prev_lr` ← sampled `lrclk`.
- The first boundary after reset only arms the block, so the partial slot in progress at reset is discarded.
- After arming, a right-slot close before any left-slot close still outputs: `left_chan` = 0 (reset value of `left_hold`).
- Slots longer than DATA_WIDTH (e.g. 32-bit slots): the MSB DATA_WIDTH bits are kept; `slot_err` is not pulsed.
- `sdata` is ignored while no `sclk` edges occur. With `sclk` stopped, outputs hold indefinitely.

## Timing
- Reset state (`reset_n`=0 at a `clk` edge):
  - `left_chan`, `right_chan`, `left_hold`, `shreg` = 0.
  - `cnt` = 0, `prev_lr` = 0, `armed` = 0.
  - `sample_valid` = 0, `slot_err` = 0.
  - Synchronizer and edge-detect flops cleared.
- Reset mid-frame: the state above applies on the next edge, and the next completed pair is dropped (re-arm required).
- Latency: let edge E be the first `clk` edge that registers `sclk`=1 in sync stage 1. The shift/boundary update occurs at edge E+SYNC_STAGES. `left_chan`/`right_chan` change at that edge, and `sample_valid`/`slot_err` are high for exactly the one cycle following it.
- Only one rising `sclk` edge is processed per `clk` cycle. No back-pressure; the consumer must take the outputs within one frame.
- `left_chan` and `right_chan` always change on the same cycle; no intermediate value is visible.

## Test plan
- Basic 16-bit frame:
  - Stimulus: `sclk` = `clk`/8, 16-bit slots, frames L=16'h8001, R=16'h7FFE repeated; reset released mid-frame.
  - Required: the first pair is dropped. Then `left_chan`=16'h8001, `right_chan`=16'h7FFE, and `sample_valid` is one cycle wide, once per frame, SYNC_STAGES+1 cycles after the `clk` edge registering the right-slot LSB→left boundary.
- Long slots:
  - Stimulus: 32-bit slots, L=32'h1234_ABCD, R=32'hFEDC_0011.
  - Required: `left_chan`=16'h1234, `right_chan`=16'hFEDC, no `slot_err`.
- Short slots:
  - Stimulus: 12-bit slots, L=12'hABC, R=12'h123.
  - Required: `left_chan`=16'hABC0, `right_chan`=16'h1230, `slot_err` pulsed once per slot (twice per frame) after arming.
- Minimum oversampling:
  - Stimulus: `sclk` = `clk`/4 with 2/2 duty, random samples over 100 frames.
  - Required: every output pair matches the transmitted pair exactly.
- Reset mid-operation:
  - Stimulus: assert `reset_n`=0 for 1 cycle during bit 7 of a right slot.
  - Required: all outputs read 0 on the next cycle. The next complete pair is not output; the pair after it is output correctly.
- Stopped clock:
  - Stimulus: hold `sclk` low for 1000 cycles while toggling `sdata`/`lrclk`.
  - Required: no `sample_valid` pulse and outputs unchanged.

Source files
------------

// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx
//
// Philips-format I2S receiver running entirely on the system clock. The
// external bit clock, word select and serial data are oversampled through
// synchronizers; rising bit-clock edges are detected in the clk domain and
// used to deserialize stereo frames into parallel left/right samples.
//
// Parameters
//   DATA_WIDTH   width of each output sample; slot bits past this are dropped
//   SYNC_STAGES  synchronizer depth on sclk/lrclk/sdata (>= 2)
//
// Ports
//   clk           system clock (>= 4x sclk, sclk high/low >= 2 clk periods)
//   reset_n       synchronous active-low reset
//   sclk          I2S bit clock (asynchronous, treated as data)
//   lrclk         word select (asynchronous), 0 = left, 1 = right
//   sdata         serial data (asynchronous), MSB first
//   left_chan     last complete left sample
//   right_chan    last complete right sample
//   sample_valid  one-cycle pulse when left_chan/right_chan update
//   slot_err      one-cycle pulse when a closed slot had < DATA_WIDTH bits
// ---------------------------------------------------------------------------
module i2s_rx #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [DATA_WIDTH-1:0] left_chan,
    output logic [DATA_WIDTH-1:0] right_chan,
    output logic                  sample_valid,
    output logic                  slot_err
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    // Synchronizer chains; bit 0 is the first stage.
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] lr_sync_q,   lr_sync_d;
    logic [SYNC_STAGES-1:0] sd_sync_q,   sd_sync_d;
    logic                   sclk_dly_q,  sclk_dly_d;

    // Deserializer state.
    logic                   prev_lr_q,   prev_lr_d;
    logic [DATA_WIDTH-1:0]  shreg_q,     shreg_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [DATA_WIDTH-1:0]  left_hold_q, left_hold_d;
    logic                   armed_q,     armed_d;

    // Registered outputs.
    logic [DATA_WIDTH-1:0]  left_q,      left_d;
    logic [DATA_WIDTH-1:0]  right_q,     right_d;
    logic                   valid_q,     valid_d;
    logic                   err_q,       err_d;

    // Edge detect and sampled inputs.
    logic                   sclk_rise;
    logic                   samp_lr;
    logic                   samp_sd;

    // Post-shift views of the deserializer for the boundary close.
    logic [DATA_WIDTH-1:0]  sh_post;
    logic [CNT_W-1:0]       cnt_post;
    logic [DATA_WIDTH-1:0]  word;
    logic                   cnt_full;

    // Synchronizers plus one extra delay on sclk for rising-edge detection.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0],   lrclk};
        sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0],   sdata};
        sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
        sclk_rise   = sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;
        samp_lr     = lr_sync_q[SYNC_STAGES-1];
        samp_sd     = sd_sync_q[SYNC_STAGES-1];
    end

    // Shift a bit in on every rising sclk edge, then close the slot when
    // lrclk changed; the boundary edge still carries the previous slot's LSB.
    always_comb begin
        prev_lr_d   = prev_lr_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        left_hold_d = left_hold_q;
        armed_d     = armed_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        cnt_full = (cnt_q >= CNT_W'(DATA_WIDTH));
        sh_post  = shreg_q;
        cnt_post = cnt_q;
        if (!cnt_full) begin
            sh_post  = {shreg_q[DATA_WIDTH-2:0], samp_sd};
            cnt_post = cnt_q + CNT_W'(1);
        end
        // Short slots are left-justified with zero LSBs.
        word = sh_post << (CNT_W'(DATA_WIDTH) - cnt_post);

        if (sclk_rise) begin
            shreg_d = sh_post;
            cnt_d   = cnt_post;

            if (samp_lr != prev_lr_q) begin
                if (armed_q) begin
                    if (cnt_post < CNT_W'(DATA_WIDTH)) begin
                        err_d = 1'b1;
                    end
                    if (!prev_lr_q) begin
                        left_hold_d = word;
                    end else begin
                        left_d  = left_hold_q;
                        right_d = word;
                        valid_d = 1'b1;
                    end
                end
                // The first boundary after reset only arms the block.
                shreg_d   = '0;
                cnt_d     = '0;
                armed_d   = 1'b1;
                prev_lr_d = samp_lr;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
            sclk_dly_q  <= 1'b0;
            prev_lr_q   <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            left_hold_q <= '0;
            armed_q     <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            lr_sync_q   <= lr_sync_d;
            sd_sync_q   <= sd_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            prev_lr_q   <= prev_lr_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            left_hold_q <= left_hold_d;
            armed_q     <= armed_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign left_chan    = left_q;
    assign right_chan   = right_q;
    assign sample_valid = valid_q;
    assign slot_err     = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx: directed bench for i2s_rx. A bit-level Philips I2S source is
// driven from tasks; a negedge monitor records sample_valid captures and
// slot_err pulses for the scenario tasks to check against fixed values.
// ---------------------------------------------------------------------------
module tb_i2s_rx;

    localparam int DW   = 16;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sclk = 1'b0;
    logic          lrclk = 1'b0;
    logic          sdata = 1'b0;
    logic [DW-1:0] left_chan;
    logic [DW-1:0] right_chan;
    logic          sample_valid;
    logic          slot_err;

    i2s_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .left_chan    (left_chan),
        .right_chan   (right_chan),
        .sample_valid (sample_valid),
        .slot_err     (slot_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int          cyc = 0;
    int          mark_cyc = 0;
    int          sv_cyc = 0;
    int          sv_run = 0;
    int          sv_wmax = 0;
    int          err_cnt = 0;
    logic [31:0] cap[$];
    int          lo_c = 4;
    int          hi_c = 4;
    logic        pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            cap.push_back({left_chan, right_chan});
            sv_cyc = cyc;
            sv_run = sv_run + 1;
            if (sv_run > sv_wmax) sv_wmax = sv_run;
        end else begin
            sv_run = 0;
        end
        if (slot_err === 1'b1) err_cnt = err_cnt + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    // One bit period: data/lrclk change while sclk is low, sampled on rise.
    task automatic send_bit(input logic lr, input logic d, input bit mark);
        sclk  = 1'b0;
        lrclk = lr;
        sdata = d;
        repeat (lo_c) @(negedge clk);
        sclk = 1'b1;
        if (mark) mark_cyc = cyc;
        repeat (hi_c) @(negedge clk);
    endtask

    // One slot; the first bit carries the previous slot's LSB (I2S delay).
    task automatic send_slot(input logic lr, input logic [31:0] word, input int w, input bit mark_first);
        for (int i = 0; i < w; i++) begin
            send_bit(lr, (i == 0) ? pend : word[w-i], (i == 0) && mark_first);
        end
        pend = word[0];
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int w);
        send_slot(1'b0, l, w, 1'b0);
        send_slot(1'b1, r, w, 1'b0);
    endtask

    task automatic idle(input int n);
        sclk = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset_n = 1'b0;
        sclk    = 1'b0;
        lrclk   = 1'b0;
        sdata   = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        cap.delete();
        err_cnt = 0;
        sv_wmax = 0;
    endtask

    // Reset, a partial left slot, then a zero right slot. The L->R boundary
    // arms; the right close then emits (0, 0) during the next left slot.
    task automatic prime(input int w);
        do_reset();
        pend = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1, 1'b0);
        pend = 1'b1;
        send_slot(1'b1, 32'h0, w, 1'b0);
    endtask

    task automatic test_reset;
        do_reset();
        n_vec++; if (left_chan !== 16'h0) begin n_err++; $display("FAIL reset_left: got %h expected 0000", left_chan); end
        n_vec++; if (right_chan !== 16'h0) begin n_err++; $display("FAIL reset_right: got %h expected 0000", right_chan); end
        n_vec++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
        n_vec++; if (slot_err !== 1'b0) begin n_err++; $display("FAIL reset_slot_err: got %b expected 0", slot_err); end
    endtask

    task automatic test_basic;
        lo_c = 4; hi_c = 4;
        prime(16);
        for (int f = 0; f < 3; f++) send_frame(32'h8001, 32'h7FFE, 16);
        send_slot(1'b0, 32'h8001, 16, 1'b1);
        idle(20);
        n_vec++; if (cap.size() !== 4) begin n_err++; $display("FAIL basic_count: got %0d expected 4", cap.size()); end
        if (cap.size() > 0) begin
            n_vec++; if (cap[0] !== 32'h0) begin n_err++; $display("FAIL basic_first_pair: got %h expected 00000000", cap[0]); end
        end
        for (int i = 1; i < cap.size(); i++) begin
            n_vec++; if (cap[i] !== 32'h8001_7FFE) begin n_err++; $display("FAIL basic_pair%0d: got %h expected 80017ffe", i, cap[i]); end
        end
        n_vec++; if (err_cnt !== 0) begin n_err++; $display("FAIL basic_slot_err: got %0d expected 0", err_cnt); end
        n_vec++; if (sv_wmax !== 1) begin n_err++; $display("FAIL basic_valid_width: got %0d expected 1", sv_wmax); end
        // sclk driven high just before edge E = mark_cyc+1; pulse seen after E+SYNC.
        n_vec++; if (sv_cyc - mark_cyc !== 1 + SYNC) begin n_err++; $display("FAIL basic_latency: got %0d expected %0d", sv_cyc - mark_cyc, 1 + SYNC); end
        n_vec++; if ({left_chan, right_chan} !== 32'h8001_7FFE) begin n_err++; $display("FAIL basic_ports: got %h expected 80017ffe", {left_chan, right_chan}); end
    endtask

    task automatic test_long;
        lo_c = 3; hi_c = 3;
        prime(32);
        for (int f = 0; f < 2; f++) send_frame(32'h1234_ABCD, 32'hFEDC_0011, 32);
        send_slot(1'b0, 32'h1234_ABCD, 32, 1'b0);
        idle(20);
        n_vec++; if (cap.size() !== 3) begin n_err++; $display("FAIL long_count: got %0d expected 3", cap.size()); end
        for (int i = 1; i < cap.size(); i++) begin
            n_vec++; if (cap[i] !== 32'h1234_FEDC) begin n_err++; $display("FAIL long_pair%0d: got %h expected 1234fedc", i, cap[i]); end
        end
        n_vec++; if (err_cnt !== 0) begin n_err++; $display("FAIL long_slot_err: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_short;
        lo_c = 4; hi_c = 4;
        prime(12);
        for (int f = 0; f < 3; f++) send_frame(32'hABC, 32'h123, 12);
        send_slot(1'b0, 32'hABC, 12, 1'b0);
        idle(20);
        n_vec++; if (cap.size() !== 4) begin n_err++; $display("FAIL short_count: got %0d expected 4", cap.size()); end
        for (int i = 1; i < cap.size(); i++) begin
            n_vec++; if (cap[i] !== 32'hABC0_1230) begin n_err++; $display("FAIL short_pair%0d: got %h expected abc01230", i, cap[i]); end
        end
        // Primed right slot close, then 3 left and 3 right closes.
        n_vec++; if (err_cnt !== 7) begin n_err++; $display("FAIL short_slot_err: got %0d expected 7", err_cnt); end
    endtask

    task automatic test_min_oversample;
        logic [31:0] exp_q[$];
        logic [15:0] l, r;
        lo_c = 2; hi_c = 2;
        prime(16);
        for (int f = 0; f < 100; f++) begin
            l = 16'($urandom);
            r = 16'($urandom);
            exp_q.push_back({l, r});
            send_frame({16'h0, l}, {16'h0, r}, 16);
        end
        send_slot(1'b0, 32'h0, 16, 1'b0);
        idle(20);
        n_vec++; if (cap.size() !== 101) begin n_err++; $display("FAIL minos_count: got %0d expected 101", cap.size()); end
        for (int i = 1; i < cap.size() && i <= 100; i++) begin
            n_vec++; if (cap[i] !== exp_q[i-1]) begin n_err++; $display("FAIL minos_pair%0d: got %h expected %h", i, cap[i], exp_q[i-1]); end
        end
        n_vec++; if (sv_wmax !== 1) begin n_err++; $display("FAIL minos_valid_width: got %0d expected 1", sv_wmax); end
        n_vec++; if (err_cnt !== 0) begin n_err++; $display("FAIL minos_slot_err: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] rb;
        rb = 16'h5A3C;
        lo_c = 4; hi_c = 4;
        prime(16);
        send_frame(32'h1357, 32'h2468, 16);
        send_slot(1'b0, 32'hC3A5, 16, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b1, (i == 0) ? pend : rb[16-i], 1'b0);
        n_vec++; if (cap.size() !== 2) begin n_err++; $display("FAIL rmid_pre_count: got %0d expected 2", cap.size()); end
        n_vec++; if ({left_chan, right_chan} !== 32'h1357_2468) begin n_err++; $display("FAIL rmid_pre_pair: got %h expected 13572468", {left_chan, right_chan}); end
        // One-cycle reset in the low phase of right-slot bit 7.
        sclk  = 1'b0;
        lrclk = 1'b1;
        sdata = rb[9];
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_vec++; if (left_chan !== 16'h0) begin n_err++; $display("FAIL rmid_left: got %h expected 0000", left_chan); end
        n_vec++; if (right_chan !== 16'h0) begin n_err++; $display("FAIL rmid_right: got %h expected 0000", right_chan); end
        n_vec++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b expected 0", sample_valid); end
        n_vec++; if (slot_err !== 1'b0) begin n_err++; $display("FAIL rmid_slot_err: got %b expected 0", slot_err); end
        cap.delete();
        err_cnt = 0;
        repeat (lo_c - 1) @(negedge clk);
        sclk = 1'b1;
        repeat (hi_c) @(negedge clk);
        for (int i = 8; i < 16; i++) send_bit(1'b1, rb[16-i], 1'b0);
        pend = rb[0];
        send_frame(32'h0F0F, 32'hF00F, 16);
        send_slot(1'b0, 32'h0, 16, 1'b0);
        idle(20);
        // Bit 7 re-arms; the closed right slot holds rb[8:0] (9 bits) left-justified.
        n_vec++; if (cap.size() !== 2) begin n_err++; $display("FAIL rmid_count: got %0d expected 2", cap.size()); end
        if (cap.size() > 0) begin
            n_vec++; if (cap[0] !== 32'h0000_1E00) begin n_err++; $display("FAIL rmid_dropped_pair: got %h expected 00001e00", cap[0]); end
        end
        if (cap.size() > 1) begin
            n_vec++; if (cap[1] !== 32'h0F0F_F00F) begin n_err++; $display("FAIL rmid_next_pair: got %h expected 0f0ff00f", cap[1]); end
        end
        n_vec++; if (err_cnt !== 1) begin n_err++; $display("FAIL rmid_slot_err_cnt: got %0d expected 1", err_cnt); end
    endtask

    task automatic test_stopped;
        cap.delete();
        err_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            sclk  = 1'b0;
            sdata = 1'($urandom);
            lrclk = 1'($urandom);
            @(negedge clk);
        end
        n_vec++; if (cap.size() !== 0) begin n_err++; $display("FAIL stop_valid: got %0d pulses expected 0", cap.size()); end
        n_vec++; if (err_cnt !== 0) begin n_err++; $display("FAIL stop_slot_err: got %0d expected 0", err_cnt); end
        n_vec++; if (left_chan !== 16'h0F0F) begin n_err++; $display("FAIL stop_left: got %h expected 0f0f", left_chan); end
        n_vec++; if (right_chan !== 16'hF00F) begin n_err++; $display("FAIL stop_right: got %h expected f00f", right_chan); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long();
        test_short();
        test_min_oversample();
        test_reset_mid();
        test_stopped();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
